// File: rtl/nonce_scheduler_pkg.sv
// Shared definitions for the nonce scheduler.
//   - Header, block, hash and nonce widths.
//   - FSM state encoding.
//   - Byte-order helpers. The SHA core works in byte-stream order.
//     Targets and nonces are numeric values.
//   - Genesis-block constants for bring-up and regression testing.
package nonce_scheduler_pkg;

  localparam int HDR_BYTES = 76;
  localparam int HDR_W     = HDR_BYTES * 8;   // 608
  localparam int NONCE_W   = 32;
  localparam int BLOCK_W   = 640;
  localparam int HASH_W    = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_REPORT,
    S_DRAIN
  } state_t;

  // Reverses the byte order of a digest.
  // Converts between stream order (byte 0 in the MSBs) and numeric order.
  function automatic logic [HASH_W-1:0] byte_reverse_256(input logic [HASH_W-1:0] v);
    logic [HASH_W-1:0] r;
    r = '0;
    for (int i = 0; i < HASH_W / 8; i++) begin
      r[8*i +: 8] = v[HASH_W-8-8*i +: 8];
    end
    return r;
  endfunction

  // Numeric nonce to the little-endian byte stream the header expects.
  function automatic logic [NONCE_W-1:0] byte_swap_32(input logic [NONCE_W-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Bitcoin genesis block.
  // GENESIS_HEADER holds header bytes 0..75, which are everything except the nonce.
  localparam logic [HDR_W-1:0] GENESIS_HEADER =
    608'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d;
  localparam logic [NONCE_W-1:0] GENESIS_NONCE  = 32'h7C2BAC1D;
  localparam logic [HASH_W-1:0]  GENESIS_TARGET = {48'h0000_0000_FFFF, 208'h0};
  localparam logic [HASH_W-1:0]  GENESIS_HASH   =
    256'h00000000_0019d668_9c085ae1_65831e93_4ff763ae_46a2a6c1_72b3f1b6_0a8ce26f;

endpackage

// File: rtl/nonce_scheduler_target_cmp.sv
// Registered difficulty comparator.
// When load is asserted, hit captures (hash_le <= target).
// The comparison is unsigned over all 256 bits.
// The result is ready during the cycle after the digest arrives, which is the CHECK cycle.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   load      capture enable (digest arriving)
//   hash_le   digest in numeric byte order
//   target    numeric target
//   hit       registered compare result
module nonce_scheduler_target_cmp
  import nonce_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HASH_W-1:0] hash_le,
  input  logic [HASH_W-1:0] target,
  output logic              hit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
    end else if (load) begin
      hit <= (hash_le <= target);
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Mining job controller in front of a double-SHA256 core.
// It walks a nonce range, starts the core once per nonce and compares each digest
// against the target. Winning nonces are offered on a valid/ready port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   job_valid/job_ready      job handshake (ready only in IDLE)
//   job_header               header bytes 0..75, byte 0 at the MSBs
//   job_target               numeric 256-bit target
//   job_nonce_start/_end     inclusive numeric nonce range
//   abort                    cancel the running job
//   core_start/core_block    start pulse and 80-byte block to the core
//   core_hash/core_done      digest (stream order) and completion pulse
//   found_valid/found_ready  winning-nonce handshake
//   found_nonce/found_hash   winning nonce and digest in numeric order
//   job_done                 one-cycle pulse at normal end or hang
//   job_error                sticky hang flag, cleared by the next job
//   busy                     high outside IDLE
//   hash_count               saturating count of digests for this job
module nonce_scheduler
  import nonce_scheduler_pkg::*;
#(
  parameter int TIMEOUT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [HDR_W-1:0]   job_header,
  input  logic [HASH_W-1:0]  job_target,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_end,
  input  logic               abort,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_block,
  input  logic [HASH_W-1:0]  core_hash,
  input  logic               core_done,
  output logic               found_valid,
  input  logic               found_ready,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0]  found_hash,
  output logic               job_done,
  output logic               job_error,
  output logic               busy,
  output logic [31:0]        hash_count
);

  // The watchdog expires on the cycle when the count would reach its all-ones value.
  // That gives 2^TIMEOUT_W-1 cycles in WAIT.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state;
  logic [HDR_W-1:0]     hdr_q;
  logic [HASH_W-1:0]    target_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [NONCE_W-1:0]   end_q;
  logic [HASH_W-1:0]    hash_le_q;
  logic [TIMEOUT_W-1:0] wdog_q;

  logic [HASH_W-1:0]    hash_le_w;
  logic                 hit;
  logic                 nonce_last;
  logic                 wdog_expire;
  logic                 digest_in;

  // Byte-order conversions are pure wiring.
  // hdr_q and nonce_q only change outside START/WAIT, so the block stays stable
  // until the matching digest comes back.
  assign core_block  = {hdr_q, byte_swap_32(nonce_q)};
  assign hash_le_w   = byte_reverse_256(core_hash);
  assign nonce_last  = (nonce_q == end_q);
  assign wdog_expire = (wdog_q == WDOG_LAST);
  assign digest_in   = (state == S_WAIT) && core_done && !abort;

  nonce_scheduler_target_cmp u_target_cmp (
    .clk     (clk),
    .rst     (rst),
    .load    (digest_in),
    .hash_le (hash_le_w),
    .target  (target_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hdr_q       <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      hash_le_q   <= '0;
      wdog_q      <= '0;
      job_ready   <= 1'b1;
      core_start  <= 1'b0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      job_done    <= 1'b0;
      job_error   <= 1'b0;
      busy        <= 1'b0;
      hash_count  <= '0;
    end else begin
      // NOTE: every assignment here is non-blocking, so every branch reads the
      // pre-edge values. The pulse outputs default low and are raised only by the
      // transition that needs them.
      core_start <= 1'b0;
      job_done   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // An abort arriving alongside a job offer is ignored here.
          if (job_valid) begin
            hdr_q      <= job_header;
            target_q   <= job_target;
            nonce_q    <= job_nonce_start;
            end_q      <= job_nonce_end;
            hash_count <= '0;
            job_error  <= 1'b0;
            if (job_nonce_end < job_nonce_start) begin
              job_done <= 1'b1;                 // empty range: no hash issued
            end else begin
              state      <= S_START;
              core_start <= 1'b1;
              job_ready  <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end

        S_START: begin
          wdog_q <= '0;
          // The core has already seen the start pulse, so an abort must drain it.
          state  <= abort ? S_DRAIN : S_WAIT;
        end

        S_WAIT: begin
          if (abort) begin
            if (core_done) begin
              // Digest arrived with the abort: the core is already free.
              state     <= S_IDLE;
              job_ready <= 1'b1;
              busy      <= 1'b0;
            end else if (wdog_expire) begin
              job_error <= 1'b1;
              state     <= S_IDLE;
              job_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              wdog_q <= wdog_q + 1'b1;
              state  <= S_DRAIN;
            end
          end else if (core_done) begin
            hash_le_q <= hash_le_w;
            if (hash_count != '1) hash_count <= hash_count + 32'd1;
            state <= S_CHECK;
          end else if (wdog_expire) begin
            job_error <= 1'b1;
            job_done  <= 1'b1;
            state     <= S_IDLE;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        S_CHECK: begin
          if (abort) begin
            state     <= S_IDLE;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (hit) begin
            found_nonce <= nonce_q;
            found_hash  <= hash_le_q;
            found_valid <= 1'b1;
            state       <= S_REPORT;
          end else if (nonce_last) begin
            // Testing for the end before the increment keeps end=0xFFFFFFFF from wrapping.
            job_done  <= 1'b1;
            state     <= S_IDLE;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            nonce_q    <= nonce_q + 32'd1;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end

        S_REPORT: begin
          if (abort) begin
            found_valid <= 1'b0;
            state       <= S_IDLE;
            job_ready   <= 1'b1;
            busy        <= 1'b0;
          end else if (found_ready) begin
            found_valid <= 1'b0;
            if (nonce_last) begin
              job_done  <= 1'b1;
              state     <= S_IDLE;
              job_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              nonce_q    <= nonce_q + 32'd1;
              core_start <= 1'b1;
              state      <= S_START;
            end
          end
        end

        S_DRAIN: begin
          // The outstanding digest is discarded and not counted.
          if (core_done) begin
            state     <= S_IDLE;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (wdog_expire) begin
            job_error <= 1'b1;
            state     <= S_IDLE;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          job_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed testbench for nonce_scheduler.
// A behavioural core model answers each start request after a programmable latency.
//   - For the genesis block it returns the known double-SHA256 digest.
//   - For any other block it returns {nonce bytes as streamed, 224 one-bits}.
//     In numeric order that digest is {224 one-bits, nonce}.
module tb_nonce_scheduler;
  import nonce_scheduler_pkg::*;

  localparam int TW = 4;

  // Genesis header and digests, written out independently of the design package.
  localparam logic [607:0] GEN_HDR =
    608'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d;
  localparam logic [639:0] GEN_BLOCK = {GEN_HDR, 32'h1dac2b7c};
  localparam logic [255:0] GEN_RAW   =
    256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;
  localparam logic [255:0] EXP_GEN_HASH =
    256'h00000000_0019d668_9c085ae1_65831e93_4ff763ae_46a2a6c1_72b3f1b6_0a8ce26f;
  localparam logic [255:0] ONES224 = {{224{1'b1}}, 32'h0};

  logic          clk, rst;
  logic          job_valid, job_ready;
  logic [607:0]  job_header;
  logic [255:0]  job_target;
  logic [31:0]   job_nonce_start, job_nonce_end;
  logic          abort;
  logic          core_start;
  logic [639:0]  core_block;
  logic [255:0]  core_hash;
  logic          core_done;
  logic          found_valid, found_ready;
  logic [31:0]   found_nonce;
  logic [255:0]  found_hash;
  logic          job_done, job_error, busy;
  logic [31:0]   hash_count;

  nonce_scheduler #(.TIMEOUT_W(TW)) dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_target      (job_target),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .abort           (abort),
    .core_start      (core_start),
    .core_block      (core_block),
    .core_hash       (core_hash),
    .core_done       (core_done),
    .found_valid     (found_valid),
    .found_ready     (found_ready),
    .found_nonce     (found_nonce),
    .found_hash      (found_hash),
    .job_done        (job_done),
    .job_error       (job_error),
    .busy            (busy),
    .hash_count      (hash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- core model ----------------
  int  core_lat    = 2;
  bit  core_hang   = 1'b0;
  int  start_count = 0;
  bit  gen_seen    = 1'b0;

  function automatic logic [255:0] core_model(input logic [639:0] blk);
    if (blk == GEN_BLOCK) return GEN_RAW;
    return {blk[31:0], {224{1'b1}}};
  endfunction

  initial begin
    bit            armed;
    int            cnt;
    logic [255:0]  resp;
    armed     = 1'b0;
    cnt       = 0;
    resp      = '0;
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (rst) begin
        armed = 1'b0;
      end else begin
        if (armed) begin
          if (cnt == 0) begin
            core_done = 1'b1;
            core_hash = resp;
            armed     = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (core_start) begin
          start_count++;
          if (core_block == GEN_BLOCK) gen_seen = 1'b1;
          resp = core_model(core_block);
          if (!core_hang) begin
            armed = 1'b1;
            cnt   = core_lat - 1;
          end
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [31:0]  xfer_nonce[$];
  logic [255:0] xfer_hash[$];
  int           done_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (found_valid && found_ready) begin
        xfer_nonce.push_back(found_nonce);
        xfer_hash.push_back(found_hash);
      end
      if (job_done) done_pulses++;
    end
  end

  // ---------------- helpers (called at a negedge) ----------------
  task automatic send_job(input logic [607:0] hdr, input logic [255:0] tgt,
                          input logic [31:0] s, input logic [31:0] e);
    job_header      = hdr;
    job_target      = tgt;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!job_done && n < budget);
    check(tag, job_done, 1);
  endtask

  task automatic wait_found(input string tag, input int budget);
    int n;
    n = 0;
    while (!found_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, found_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int           s0, d0, k, n;
    bit           stable, busy_ok, fv_seen;
    logic [31:0]  n0;
    logic [255:0] h0;

    rst = 1'b1; job_valid = 1'b0; job_header = '0; job_target = '0;
    job_nonce_start = '0; job_nonce_end = '0; abort = 1'b0; found_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ---- reset state ----
    check("rst_job_ready",   job_ready,   1);
    check("rst_busy",        busy,        0);
    check("rst_core_start",  core_start,  0);
    check("rst_found_valid", found_valid, 0);
    check("rst_job_done",    job_done,    0);
    check("rst_job_error",   job_error,   0);
    check("rst_hash_count",  hash_count,  0);
    check("rst_found_nonce", found_nonce, 0);

    // ---- genesis: one hit in 0x7C2BAC1B..0x7C2BAC1F ----
    core_lat = 2; found_ready = 1'b1;
    xfer_nonce.delete(); xfer_hash.delete();
    s0 = start_count; d0 = done_pulses;
    send_job(GENESIS_HEADER, GENESIS_TARGET, 32'h7C2BAC1B, 32'h7C2BAC1F);
    check("gen_start_latency", core_start, 1);
    check("gen_first_block",   core_block, {GEN_HDR, 32'h1bac2b7c});
    check("gen_busy",          busy,       1);
    check("gen_job_ready_low", job_ready,  0);
    wait_done("gen_done", 200);
    check("gen_hash_count",  hash_count, 5);
    check("gen_starts",      start_count - s0, 5);
    check("gen_block_seen",  gen_seen, 1);
    check("gen_xfer_count",  xfer_nonce.size(), 1);
    if (xfer_nonce.size() > 0) begin
      check("gen_found_nonce", xfer_nonce[0], 32'h7C2BAC1D);
      check("gen_found_hash",  xfer_hash[0],  EXP_GEN_HASH);
      check("gen_found_pkg",   xfer_hash[0],  GENESIS_HASH);
    end
    @(negedge clk);
    check("gen_idle_ready",  job_ready, 1);
    check("gen_done_pulses", done_pulses - d0, 1);

    // ---- all-ones target, 0x10..0x12, hold found_ready low first ----
    found_ready = 1'b0;
    xfer_nonce.delete(); xfer_hash.delete();
    send_job(GENESIS_HEADER, {256{1'b1}}, 32'h10, 32'h12);
    wait_found("hold_first_found", 50);
    n0 = found_nonce; h0 = found_hash;
    check("hold_first_nonce", found_nonce, 32'h10);
    s0 = start_count; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!found_valid || found_nonce !== n0 || found_hash !== h0) stable = 1'b0;
    end
    check("hold_stable",   stable, 1);
    check("hold_no_start", start_count - s0, 0);
    found_ready = 1'b1;
    wait_done("hold_done", 200);
    check("hold_xfer_count", xfer_nonce.size(), 3);
    if (xfer_nonce.size() == 3) begin
      check("hold_nonce0", xfer_nonce[0], 32'h10);
      check("hold_nonce1", xfer_nonce[1], 32'h11);
      check("hold_nonce2", xfer_nonce[2], 32'h12);
      check("hold_hash1",  xfer_hash[1],  ONES224 | 256'h11);
    end
    check("hold_hash_count", hash_count, 3);
    @(negedge clk);
    check("hold_fv_low", found_valid, 0);

    // ---- single nonce 0xFFFFFFFF, target 0: no wrap ----
    xfer_nonce.delete(); xfer_hash.delete();
    s0 = start_count;
    send_job(GENESIS_HEADER, '0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("wrap_done", 100);
    check("wrap_hash_count", hash_count, 1);
    repeat (10) @(negedge clk);
    check("wrap_starts",  start_count - s0, 1);
    check("wrap_no_xfer", xfer_nonce.size(), 0);
    check("wrap_idle",    job_ready, 1);

    // ---- abort 3 cycles after core_start ----
    core_lat = 8;
    xfer_nonce.delete(); xfer_hash.delete();
    s0 = start_count; d0 = done_pulses;
    send_job(GENESIS_HEADER, '0, 32'h0, 32'd100);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    busy_ok = 1'b1; fv_seen = 1'b0; n = 0;
    while (!core_done && n < 50) begin
      if (!busy) busy_ok = 1'b0;
      if (found_valid) fv_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check("abort_core_done_seen", core_done, 1);
    check("abort_busy_held",      busy_ok, 1);
    check("abort_busy_at_done",   busy, 1);
    @(negedge clk);
    check("abort_idle_ready", job_ready, 1);
    check("abort_idle_busy",  busy, 0);
    repeat (5) @(negedge clk);
    check("abort_no_found",     fv_seen, 0);
    check("abort_no_job_done",  done_pulses - d0, 0);
    check("abort_not_counted",  hash_count, 0);
    check("abort_single_start", start_count - s0, 1);

    // ---- hung core: watchdog ----
    core_hang = 1'b1; core_lat = 2;
    send_job(GENESIS_HEADER, '0, 32'h0, 32'h0);
    @(posedge clk);        // START -> WAIT
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!job_done && k < 40);
    check("wdog_done_pulse", job_done, 1);
    check("wdog_cycles",     k, 15);
    check("wdog_error",      job_error, 1);
    @(negedge clk);
    check("wdog_idle_ready", job_ready, 1);
    repeat (5) @(negedge clk);
    check("wdog_error_sticky", job_error, 1);
    core_hang = 1'b0;

    // ---- empty range end<start; also clears job_error ----
    s0 = start_count; d0 = done_pulses;
    send_job(GENESIS_HEADER, '0, 32'd5, 32'd4);
    check("empty_done_next",   job_done, 1);
    check("empty_ready",       job_ready, 1);
    check("empty_busy",        busy, 0);
    check("empty_error_clear", job_error, 0);
    repeat (5) @(negedge clk);
    check("empty_no_start",    start_count - s0, 0);
    check("empty_one_done",    done_pulses - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
